rf_wb_arbiter: RTL and testbench

Write-back arbiter for the 8x16 register file's single write port. Two producers compete for the port: the ALU result path and the memory load path. Each uses a valid/ready handshake. The block grants one producer per cycle using round-robin and drives the register file write port from a registered output stage. It also publishes a pending-write mask so decode can detect hazards, plus a saturating conflict counter for performance debug.

---
 rtl/rf_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin write-back arbiter for the register file write port
module rf_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_W-1:0]     alu_addr,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  rf_wr_en,
  output logic [ADDR_W-1:0]     rf_wr_addr,
  output logic [DATA_W-1:0]     rf_wr_data,
  output logic [(2**ADDR_W)-1:0] pend_mask,
  output logic [CNT_W-1:0]      conflict_cnt
);

  // Which producer won the most recent transfer; the other one wins the next conflict.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  src_e               last_grant_q, last_grant_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               grant_alu;
  logic               grant_mem;
  logic               alu_xfer;
  logic               mem_xfer;
  logic               conflict;

  // Round-robin grant from current requests; nothing is granted in reset or while frozen.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (rst_n && !hold) begin
      if (alu_valid && mem_valid) begin
        if (last_grant_q == SRC_MEM) begin
          grant_alu = 1'b1;
        end else begin
          grant_mem = 1'b1;
        end
      end else begin
        grant_alu = alu_valid;
        grant_mem = mem_valid;
      end
    end
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;
  assign alu_xfer  = alu_valid & grant_alu;
  assign mem_xfer  = mem_valid & grant_mem;
  assign conflict  = alu_valid & mem_valid & ~hold;

  // Next-state for round-robin pointer, output stage and conflict counter.
  always_comb begin
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    cnt_d        = cnt_q;
    if (alu_xfer) begin
      last_grant_d = SRC_ALU;
      wr_en_d      = 1'b1;
      wr_addr_d    = alu_addr;
      wr_data_d    = alu_data;
    end else if (mem_xfer) begin
      last_grant_d = SRC_MEM;
      wr_en_d      = 1'b1;
      wr_addr_d    = mem_addr;
      wr_data_d    = mem_data;
    end
    // Saturate rather than wrap so a long stall is still visible as all ones.
    if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset makes the ALU win the first conflict and drops any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= SRC_MEM;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cnt_q        <= cnt_d;
    end
  end

  // Pending-write mask for decode hazard detection, one-hot of the staged address.
  always_comb begin
    pend_mask = '0;
    if (wr_en_q) begin
      pend_mask[wr_addr_q] = 1'b1;
    end
  end

  assign rf_wr_en     = wr_en_q;
  assign rf_wr_addr   = wr_addr_q;
  assign rf_wr_data   = wr_data_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [2:0]  alu_addr, mem_addr;
  logic [15:0] alu_data, mem_data;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic [7:0]  pend_mask;
  logic [7:0]  conflict_cnt;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.DATA_W(16), .ADDR_W(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .pend_mask(pend_mask), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT write port.
  logic [15:0] rf [8];
  always @(posedge clk) begin
    if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] onehot(input logic en, input logic [2:0] a);
    logic [7:0] m;
    m = 8'h00;
    if (en) m = 8'h01 << a;
    return m;
  endfunction

  task automatic set_in(input logic h, input logic av, input logic [2:0] aa, input logic [15:0] ad,
                        input logic mv, input logic [2:0] ma, input logic [15:0] md);
    hold = h; alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic        h;
    logic        av;
    logic [2:0]  aa;
    logic [15:0] ad;
    logic        mv;
    logic [2:0]  ma;
    logic [15:0] md;
    logic        e_ar;
    logic        e_mr;
    logic        e_en;
    logic [2:0]  e_addr;
    logic [15:0] e_data;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tbl [12];

  // Reference model state for the random phase.
  int          m_last;      // 0 = ALU won last, 1 = MEM won last
  logic        m_en;
  logic [2:0]  m_addr;
  logic [15:0] m_data;
  int          m_cnt;
  logic [15:0] m_rf [8];

  initial begin
    logic [15:0] snap;
    logic        a_pend, m_pend;
    logic [2:0]  a_a, m_a;
    logic [15:0] a_d, m_d;
    logic        h, pick_alu, pick_mem;

    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;

    // Reset state
    #3;
    chk("reset_wr_en", 32'(rf_wr_en), 32'd0);
    chk("reset_wr_addr", 32'(rf_wr_addr), 32'd0);
    chk("reset_wr_data", 32'(rf_wr_data), 32'd0);
    chk("reset_pend", 32'(pend_mask), 32'd0);
    chk("reset_cnt", 32'(conflict_cnt), 32'd0);
    alu_valid = 1'b1; mem_valid = 1'b1;
    #1;
    chk("reset_alu_ready", 32'(alu_ready), 32'd0);
    chk("reset_mem_ready", 32'(mem_ready), 32'd0);
    do_reset();

    // Single ALU request
    set_in(1'b0, 1'b1, 3'd3, 16'hABCD, 1'b0, 3'd0, 16'h0);
    #1;
    chk("single_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    set_in(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    chk("single_en", 32'(rf_wr_en), 32'd1);
    chk("single_addr", 32'(rf_wr_addr), 32'd3);
    chk("single_data", 32'(rf_wr_data), 32'hABCD);
    chk("single_pend", 32'(pend_mask), 32'h08);

    // Vector table, applied from a fresh reset
    tbl[0]  = '{1'b0, 1'b1, 3'd1, 16'h0011, 1'b1, 3'd2, 16'h0022, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0011, 8'd1};
    tbl[1]  = '{1'b0, 1'b1, 3'd1, 16'h0011, 1'b1, 3'd2, 16'h0022, 1'b0, 1'b1, 1'b1, 3'd2, 16'h0022, 8'd2};
    tbl[2]  = '{1'b0, 1'b1, 3'd1, 16'h0011, 1'b1, 3'd2, 16'h0022, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0011, 8'd3};
    tbl[3]  = '{1'b0, 1'b1, 3'd1, 16'h0011, 1'b1, 3'd2, 16'h0022, 1'b0, 1'b1, 1'b1, 3'd2, 16'h0022, 8'd4};
    tbl[4]  = '{1'b1, 1'b1, 3'd1, 16'h0011, 1'b1, 3'd2, 16'h0022, 1'b0, 1'b0, 1'b0, 3'd2, 16'h0022, 8'd4};
    tbl[5]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'h0066, 1'b0, 1'b0, 1'b0, 3'd2, 16'h0022, 8'd4};
    tbl[6]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'h0066, 1'b0, 1'b0, 1'b0, 3'd2, 16'h0022, 8'd4};
    tbl[7]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'h0066, 1'b0, 1'b1, 1'b1, 3'd6, 16'h0066, 8'd4};
    tbl[8]  = '{1'b0, 1'b1, 3'd7, 16'h7777, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd7, 16'h7777, 8'd4};
    tbl[9]  = '{1'b0, 1'b1, 3'd0, 16'h00A0, 1'b1, 3'd4, 16'h0044, 1'b0, 1'b1, 1'b1, 3'd4, 16'h0044, 8'd5};
    tbl[10] = '{1'b0, 1'b1, 3'd0, 16'h00A0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd0, 16'h00A0, 8'd5};
    tbl[11] = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 16'h00A0, 8'd5};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].h, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].mv, tbl[i].ma, tbl[i].md);
      #1;
      chk($sformatf("tbl%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
      chk($sformatf("tbl%0d_mem_ready", i), 32'(mem_ready), 32'(tbl[i].e_mr));
      tick();
      chk($sformatf("tbl%0d_en", i), 32'(rf_wr_en), 32'(tbl[i].e_en));
      chk($sformatf("tbl%0d_addr", i), 32'(rf_wr_addr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_data", i), 32'(rf_wr_data), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_pend", i), 32'(pend_mask), 32'(onehot(tbl[i].e_en, tbl[i].e_addr)));
      chk($sformatf("tbl%0d_cnt", i), 32'(conflict_cnt), 32'(tbl[i].e_cnt));
    end

    // Same-address collision: ALU first, then MEM; later write wins
    do_reset();
    set_in(1'b0, 1'b1, 3'd5, 16'h1111, 1'b1, 3'd5, 16'h2222);
    tick();
    chk("coll_first_data", 32'(rf_wr_data), 32'h1111);
    alu_valid = 1'b0;
    tick();
    chk("coll_second_en", 32'(rf_wr_en), 32'd1);
    chk("coll_second_data", 32'(rf_wr_data), 32'h2222);
    mem_valid = 1'b0;
    tick();
    tick();
    chk("coll_rf5", 32'(rf[5]), 32'h2222);

    // Conflict counter saturation
    do_reset();
    set_in(1'b0, 1'b1, 3'd1, 16'h0001, 1'b1, 3'd2, 16'h0002);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 254) chk("sat_at_255", 32'(conflict_cnt), 32'hFF);
    end
    chk("sat_after_300", 32'(conflict_cnt), 32'hFF);

    // Reset while a write is staged
    do_reset();
    snap = rf[6];
    set_in(1'b0, 1'b1, 3'd6, 16'hDEAD, 1'b1, 3'd6, 16'hBEEF);
    tick();
    set_in(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    chk("midrst_pre_en", 32'(rf_wr_en), 32'd1);
    chk("midrst_pre_cnt", 32'(conflict_cnt), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_en", 32'(rf_wr_en), 32'd0);
    chk("midrst_pend", 32'(pend_mask), 32'd0);
    chk("midrst_cnt", 32'(conflict_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("midrst_after_en", 32'(rf_wr_en), 32'd0);
    chk("midrst_rf6", 32'(rf[6]), 32'(snap));

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = rf[i];
    m_last = 1; m_en = 1'b0; m_addr = 3'd0; m_data = 16'h0; m_cnt = 0;
    a_pend = 1'b0; m_pend = 1'b0;
    a_a = 3'd0; m_a = 3'd0; a_d = 16'h0; m_d = 16'h0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!a_pend && ($urandom_range(0, 2) != 0)) begin
        a_pend = 1'b1; a_a = 3'($urandom_range(0, 7)); a_d = 16'($urandom);
      end
      if (!m_pend && ($urandom_range(0, 2) != 0)) begin
        m_pend = 1'b1; m_a = 3'($urandom_range(0, 7)); m_d = 16'($urandom);
      end
      h = ($urandom_range(0, 7) == 0);
      set_in(h, a_pend, a_a, a_d, m_pend, m_a, m_d);

      // Who should win: nobody when frozen, the sole requester, else whoever did not win last.
      pick_alu = 1'b0; pick_mem = 1'b0;
      if (!h) begin
        if (a_pend && m_pend) begin
          if (m_last == 1) pick_alu = 1'b1; else pick_mem = 1'b1;
        end else if (a_pend) pick_alu = 1'b1;
        else if (m_pend) pick_mem = 1'b1;
      end
      #1;
      chk("rnd_alu_ready", 32'(alu_ready), 32'(pick_alu));
      chk("rnd_mem_ready", 32'(mem_ready), 32'(pick_mem));
      tick();

      if (m_en) m_rf[m_addr] = m_data;
      if (!h && a_pend && m_pend) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      m_en = pick_alu | pick_mem;
      if (pick_alu) begin
        m_addr = a_a; m_data = a_d; m_last = 0; a_pend = 1'b0;
      end else if (pick_mem) begin
        m_addr = m_a; m_data = m_d; m_last = 1; m_pend = 1'b0;
      end
      chk("rnd_en", 32'(rf_wr_en), 32'(m_en));
      chk("rnd_addr", 32'(rf_wr_addr), 32'(m_addr));
      chk("rnd_data", 32'(rf_wr_data), 32'(m_data));
      chk("rnd_pend", 32'(pend_mask), 32'(onehot(m_en, m_addr)));
      chk("rnd_cnt", 32'(conflict_cnt), 32'(m_cnt));
    end
    set_in(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    tick();
    if (m_en) m_rf[m_addr] = m_data;
    tick();
    for (int i = 0; i < 8; i++) chk($sformatf("rnd_rf%0d", i), 32'(rf[i]), 32'(m_rf[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
